// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback source select.
// Drives the register file write port one cycle after the MEM stage, and
// holds the sticky processor halt flag and the retired-instruction counter.
//
// Handshake: 'en' is the advance signal from the hazard unit. A MEM-stage
// slot moves into this stage on a posedge where en=1 and flush=0 and the
// core is not halted. 'in_valid' qualifies the slot contents. There is no
// back-pressure from writeback; the register file always accepts the write.
module mem_wb_stage #(
    parameter int WORD_W = 32,
    parameter int SEL_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_regwrite,
    input  logic [SEL_W-1:0]  in_wsel,
    input  logic [1:0]        in_wbsel,
    input  logic [WORD_W-1:0] in_alu_out,
    input  logic [WORD_W-1:0] in_dmem_data,
    input  logic [WORD_W-1:0] in_npc,
    input  logic [15:0]       in_imm16,
    input  logic              in_halt,
    output logic              WEN,
    output logic [SEL_W-1:0]  wsel,
    output logic [WORD_W-1:0] wdat,
    output logic              wb_valid,
    output logic              halt,
    output logic [31:0]       retired_count
);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_DMEM = 2'b01;
    localparam logic [1:0] WB_NPC  = 2'b10;
    localparam logic [1:0] WB_LUI  = 2'b11;

    logic              valid_q;
    logic              regwrite_q;
    logic [SEL_W-1:0]  wsel_q;
    logic [1:0]        wbsel_q;
    logic [WORD_W-1:0] alu_q;
    logic [WORD_W-1:0] dmem_q;
    logic [WORD_W-1:0] npc_q;
    logic [15:0]       imm_q;
    logic              halt_field_q;
    logic              halted_q;
    logic [31:0]       count_q;

    // A slot advances and retires only when nothing blocks it.
    logic advance;
    assign advance = en && !flush && !halted_q;

    // Pipeline register, sticky halt and saturating retire counter.
    // Flush and halted both produce a bubble; data fields are left as-is.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            wsel_q       <= '0;
            wbsel_q      <= WB_ALU;
            alu_q        <= '0;
            dmem_q       <= '0;
            npc_q        <= '0;
            imm_q        <= '0;
            halt_field_q <= 1'b0;
            halted_q     <= 1'b0;
            count_q      <= '0;
        end else if (flush || halted_q) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            halt_field_q <= 1'b0;
        end else if (en) begin
            valid_q      <= in_valid;
            regwrite_q   <= in_regwrite;
            wsel_q       <= in_wsel;
            wbsel_q      <= in_wbsel;
            alu_q        <= in_alu_out;
            dmem_q       <= in_dmem_data;
            npc_q        <= in_npc;
            imm_q        <= in_imm16;
            halt_field_q <= in_halt;
            if (in_valid && in_halt) begin
                halted_q <= 1'b1;
            end
            if (in_valid && (count_q != 32'hFFFF_FFFF)) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // Writeback source select; driven regardless of WEN.
    always_comb begin
        wdat = alu_q;
        case (wbsel_q)
            WB_ALU:  wdat = alu_q;
            WB_DMEM: wdat = dmem_q;
            WB_NPC:  wdat = npc_q;
            WB_LUI:  wdat = {imm_q, {(WORD_W-16){1'b0}}};
            default: wdat = alu_q;
        endcase
    end

    // Register file port; writes to $0 never leave this stage.
    assign WEN           = valid_q && regwrite_q && (wsel_q != '0);
    assign wsel          = wsel_q;
    assign wb_valid      = valid_q;
    assign halt          = halted_q;
    assign retired_count = count_q;

    // halt_field_q and advance are kept for debug visibility of the slot.
    logic unused_ok;
    assign unused_ok = halt_field_q ^ advance;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: reset, table-driven vectors, hand-written
// corner sequences, then random stimulus against a behavioural model.
module tb_mem_wb_stage;

    localparam int WORD_W = 32;
    localparam int SEL_W  = 5;

    logic              CLK;
    logic              nRST;
    logic              en;
    logic              flush;
    logic              in_valid;
    logic              in_regwrite;
    logic [SEL_W-1:0]  in_wsel;
    logic [1:0]        in_wbsel;
    logic [WORD_W-1:0] in_alu_out;
    logic [WORD_W-1:0] in_dmem_data;
    logic [WORD_W-1:0] in_npc;
    logic [15:0]       in_imm16;
    logic              in_halt;
    logic              WEN;
    logic [SEL_W-1:0]  wsel;
    logic [WORD_W-1:0] wdat;
    logic              wb_valid;
    logic              halt;
    logic [31:0]       retired_count;

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_stage #(.WORD_W(WORD_W), .SEL_W(SEL_W)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_wsel(in_wsel),
        .in_wbsel(in_wbsel), .in_alu_out(in_alu_out), .in_dmem_data(in_dmem_data),
        .in_npc(in_npc), .in_imm16(in_imm16), .in_halt(in_halt),
        .WEN(WEN), .wsel(wsel), .wdat(wdat), .wb_valid(wb_valid),
        .halt(halt), .retired_count(retired_count)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        en, flush, valid, regwrite;
        logic [4:0]  wsel;
        logic [1:0]  wbsel;
        logic [31:0] alu, dmem, npc;
        logic [15:0] imm;
        logic        hlt;
        logic        e_wen;
        logic [4:0]  e_wsel;
        logic [31:0] e_wdat;
        logic        e_valid, e_halt;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_wen, input logic [4:0] e_wsel,
                             input logic [31:0] e_wdat, input logic e_valid,
                             input logic e_halt, input logic [31:0] e_count);
        check({tag, ".WEN"}, {31'd0, WEN}, {31'd0, e_wen});
        check({tag, ".wsel"}, {27'd0, wsel}, {27'd0, e_wsel});
        check({tag, ".wdat"}, wdat, e_wdat);
        check({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, e_valid});
        check({tag, ".halt"}, {31'd0, halt}, {31'd0, e_halt});
        check({tag, ".count"}, retired_count, e_count);
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input logic rw,
                         input logic [4:0] ws, input logic [1:0] wb, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [31:0] np, input logic [15:0] im,
                         input logic h);
        en = e; flush = f; in_valid = v; in_regwrite = rw; in_wsel = ws;
        in_wbsel = wb; in_alu_out = alu; in_dmem_data = dm; in_npc = np;
        in_imm16 = im; in_halt = h;
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic do_reset();
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        check_all("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic add_vec(input logic e, input logic f, input logic v, input logic rw,
                           input logic [4:0] ws, input logic [1:0] wb, input logic [31:0] alu,
                           input logic [31:0] dm, input logic [31:0] np, input logic [15:0] im,
                           input logic h, input logic x_wen, input logic [4:0] x_wsel,
                           input logic [31:0] x_wdat, input logic x_valid, input logic x_halt,
                           input logic [31:0] x_count);
        vec_t t;
        t.en = e; t.flush = f; t.valid = v; t.regwrite = rw; t.wsel = ws; t.wbsel = wb;
        t.alu = alu; t.dmem = dm; t.npc = np; t.imm = im; t.hlt = h;
        t.e_wen = x_wen; t.e_wsel = x_wsel; t.e_wdat = x_wdat; t.e_valid = x_valid;
        t.e_halt = x_halt; t.e_count = x_count;
        vecs.push_back(t);
    endtask

    // Behavioural model state: the instruction currently in writeback.
    typedef struct {
        logic        valid, regwrite;
        logic [4:0]  wsel;
        logic [1:0]  wbsel;
        logic [31:0] alu, dmem, npc;
        logic [15:0] imm;
    } slot_t;

    function automatic logic [31:0] model_wdat(input slot_t s);
        logic [31:0] srcs[4];
        srcs[0] = s.alu;
        srcs[1] = s.dmem;
        srcs[2] = s.npc;
        srcs[3] = {s.imm, 16'h0000};
        return srcs[s.wbsel];
    endfunction

    initial begin
        slot_t       m;
        logic        m_halted;
        longint      m_count;
        logic        r_en, r_fl, r_v, r_rw, r_h;
        logic [4:0]  r_ws;
        logic [1:0]  r_wb;
        logic [31:0] r_alu, r_dm, r_np;
        logic [15:0] r_im;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        #13;
        check_all("por", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Reset mid-stream: ADD $3 = 5 then async reset between edges.
        drive(1, 0, 1, 1, 5'd3, 2'b00, 32'h5, 32'h0, 32'h0, 16'h0, 0);
        step();
        check_all("add3", 1'b1, 5'd3, 32'h5, 1'b1, 1'b0, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Table: writeback mux, $0 suppression, stall, flush, bubble, flush+halt.
        add_vec(1,0,1,1, 5'd4, 2'b00, 32'h11, 32'h22, 32'h104, 16'hBEEF, 0, 1, 5'd4, 32'h11,       1, 0, 32'd1);
        add_vec(1,0,1,1, 5'd4, 2'b01, 32'h11, 32'h22, 32'h104, 16'hBEEF, 0, 1, 5'd4, 32'h22,       1, 0, 32'd2);
        add_vec(1,0,1,1, 5'd4, 2'b10, 32'h11, 32'h22, 32'h104, 16'hBEEF, 0, 1, 5'd4, 32'h104,      1, 0, 32'd3);
        add_vec(1,0,1,1, 5'd4, 2'b11, 32'h11, 32'h22, 32'h104, 16'hBEEF, 0, 1, 5'd4, 32'hBEEF0000, 1, 0, 32'd4);
        add_vec(1,0,1,1, 5'd0, 2'b00, 32'hFFFFFFFF, 0, 0, 0,             0, 0, 5'd0, 32'hFFFFFFFF, 1, 0, 32'd5);
        add_vec(1,0,1,1, 5'd7, 2'b00, 32'h55, 0, 0, 0,                   0, 1, 5'd7, 32'h55,       1, 0, 32'd6);
        add_vec(0,0,1,1, 5'd9, 2'b00, 32'h99, 0, 0, 0,                   0, 1, 5'd7, 32'h55,       1, 0, 32'd6);
        add_vec(0,0,1,1, 5'd9, 2'b01, 32'h99, 32'h98, 0, 0,              0, 1, 5'd7, 32'h55,       1, 0, 32'd6);
        add_vec(0,0,1,1, 5'd9, 2'b00, 32'h99, 0, 0, 0,                   0, 1, 5'd7, 32'h55,       1, 0, 32'd6);
        add_vec(1,1,1,1, 5'd9, 2'b00, 32'h99, 0, 0, 0,                   0, 0, 5'd7, 32'h55,       0, 0, 32'd6);
        add_vec(1,0,0,1, 5'd8, 2'b00, 32'h77, 0, 0, 0,                   0, 0, 5'd8, 32'h77,       0, 0, 32'd6);
        add_vec(1,1,1,1, 5'd2, 2'b00, 32'h66, 0, 0, 0,                   1, 0, 5'd8, 32'h77,       0, 0, 32'd6);
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].flush, vecs[i].valid, vecs[i].regwrite, vecs[i].wsel,
                  vecs[i].wbsel, vecs[i].alu, vecs[i].dmem, vecs[i].npc, vecs[i].imm, vecs[i].hlt);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_wsel, vecs[i].e_wdat,
                      vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_count);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Halt: the HALT (with regwrite) is written and counted, then bubbles forever.
        drive(1, 0, 1, 1, 5'd2, 2'b00, 32'hAA, 0, 0, 0, 1);
        step();
        check_all("halt_cap", 1'b1, 5'd2, 32'hAA, 1'b1, 1'b1, 32'd1);
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 1, 1, 5'd10 + 5'(k), 2'b00, 32'h100 + k, 0, 0, 0, 0);
            step();
            check_all($sformatf("halted%0d", k), 1'b0, 5'd2, 32'hAA, 1'b0, 1'b1, 32'd1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Counter saturation near the top of the range.
        @(negedge CLK);
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 1, 5'd5, 2'b00, 32'h200 + k, 0, 0, 0, 0);
            step();
            check_all($sformatf("sat%0d", k), 1'b1, 5'd5, 32'h200 + k, 1'b1, 1'b0, 32'hFFFF_FFFF);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Random stimulus against the behavioural model.
        m = '{valid: 1'b0, regwrite: 1'b0, wsel: 5'd0, wbsel: 2'b00,
              alu: 32'd0, dmem: 32'd0, npc: 32'd0, imm: 16'd0};
        m_halted = 1'b0;
        m_count  = 0;
        for (int k = 0; k < 300; k++) begin
            r_en  = ($urandom_range(0, 3) != 0);
            r_fl  = ($urandom_range(0, 7) == 0);
            r_v   = ($urandom_range(0, 4) != 0);
            r_rw  = $urandom_range(0, 1);
            r_ws  = 5'($urandom_range(0, 31));
            r_wb  = 2'($urandom_range(0, 3));
            r_alu = $urandom;
            r_dm  = $urandom;
            r_np  = $urandom;
            r_im  = 16'($urandom);
            r_h   = (k > 200) && ($urandom_range(0, 15) == 0);
            drive(r_en, r_fl, r_v, r_rw, r_ws, r_wb, r_alu, r_dm, r_np, r_im, r_h);
            // Model: a bubble while flushing or halted; otherwise accept on en.
            if (r_fl || m_halted) begin
                m.valid = 1'b0;
                m.regwrite = 1'b0;
            end else if (r_en) begin
                m = '{valid: r_v, regwrite: r_rw, wsel: r_ws, wbsel: r_wb,
                      alu: r_alu, dmem: r_dm, npc: r_np, imm: r_im};
                if (r_v && r_h) m_halted = 1'b1;
                if (r_v) m_count = (m_count + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_count + 1;
            end
            step();
            check_all($sformatf("rnd%0d", k), m.valid && m.regwrite && (m.wsel != 0),
                      m.wsel, model_wdat(m), m.valid, m_halted, 32'(m_count));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback select for the pipelined MIPS core.
- Latches memory-stage results on the rising clock edge and drives the register file write port (WEN, wsel, wdat). The register file commits on the falling edge of the same cycle, which gives write-before-read for the decode stage.
- Also owns the sticky halt flag and the retired-instruction counter.

Parameters:
- WORD_W, 32, datapath width.
- SEL_W, 5, register select width.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- nRST  input  1  asynchronous, active-low reset.
- en  input  1  advance enable from hazard unit; 0 = stall (hold contents).
- flush  input  1  insert bubble.
- in_valid  input  1  MEM-stage slot holds a real instruction.
- in_regwrite  input  1  instruction writes a GPR.
- in_wsel  input  SEL_W  destination register.
- in_wbsel  input  2  writeback source: 00 ALU, 01 dmem load data, 10 npc (JAL link), 11 LUI.
- in_alu_out  input  WORD_W  ALU result.
- in_dmem_data  input  WORD_W  load data.
- in_npc  input  WORD_W  PC+4 of the instruction.
- in_imm16  input  16  immediate field.
- in_halt  input  1  instruction is HALT.
- WEN  output  1  register file write enable.
- wsel  output  SEL_W  register file write select.
- wdat  output  WORD_W  register file write data.
- wb_valid  output  1  stage holds a valid instruction (for forwarding unit).
- halt  output  1  sticky processor halt.
- retired_count  output  32  instructions retired.

Behaviour:
- Reset (nRST=0, async, takes effect immediately, including mid-stall or mid-flush):
  - All latched fields clear: valid=0, regwrite=0, wsel=0, wbsel=00, all data fields 0, halt=0, retired_count=0.
  - Outputs after reset: WEN=0, wsel=0, wdat=0, wb_valid=0, halt=0, retired_count=0.
- Posedge update priority is flush > halted > en > hold:
  - flush=1: valid<=0, regwrite<=0, halt-field<=0; data fields unchanged. The bubble takes priority even when en=1.
  - halt=1 (already halted): identical to flush, so the stage is a permanent bubble.
  - en=1: capture all in_* fields; valid<=in_valid.
  - en=0: hold all fields; no count change.
- Combinational outputs from latched fields:
  - WEN = valid & regwrite & (wsel != 0). No write to $0 ever leaves this stage.
  - wdat by wbsel: ALU -> alu_out; 01 -> dmem_data; 10 -> npc; 11 -> {imm16, 16'h0000}. wdat is driven even when WEN=0.
  - wsel passes through the latched value.
  - wb_valid = valid.
- Latency: one cycle from MEM-stage inputs to the write port. The register file commits on the following negedge, so a result captured at posedge N is readable by decode after negedge N.
- Halt:
  - halt sets at the posedge that captures in_valid=1 & in_halt=1 with en=1, flush=0, halt=0. The HALT instruction itself is latched as valid.
  - Sticky until nRST.
  - If the HALT has regwrite=1 it is still written in that cycle.
- retired_count:
  - +1 at each posedge where en=1, flush=0, halt=0 (pre-edge) and in_valid=1. The HALT counts.
  - Saturates at 0xFFFFFFFF with no wrap.
  - Stalls, flushes and bubbles (in_valid=0) do not count.
- Simultaneous flush and en with a valid HALT input: the flush wins. No halt, no count.
- Stall with valid contents: WEN stays asserted each cycle with the same wsel/wdat. Re-writing the same value is harmless and is the required behaviour.

Test Plan:
- Reset mid-stream: capture ADD $3 (alu_out=0x0000_0005), then assert nRST=0 between edges -> WEN, wdat, wb_valid, retired_count all drop to 0 immediately, with no waiting for a clock edge.
- Writeback mux, four consecutive captures all writing $4, with alu_out=0x11, dmem_data=0x22, npc=0x0000_0104, imm16=0xBEEF:
  - wbsel=00 -> wdat=0x11
  - wbsel=01 -> wdat=0x22
  - wbsel=10 -> wdat=0x104
  - wbsel=11 -> wdat=0xBEEF0000
  - WEN=1 each cycle; retired_count=4.
- $0 suppression: in_regwrite=1, in_wsel=0, alu_out=0xFFFF_FFFF -> WEN=0, wb_valid=1, retired_count increments.
- Stall then flush:
  - Capture write $7=0x55, then en=0 for 3 cycles -> WEN=1, wsel=7 held, count unchanged.
  - Then flush=1, en=1 with a valid input -> wb_valid=0, WEN=0, count unchanged.
- Halt:
  - Valid HALT captured -> halt=1 next cycle; count includes the HALT.
  - Then 5 more valid in_regwrite captures -> WEN stays 0, count frozen, halt stays 1 until nRST.
- Counter saturation: force retired_count=0xFFFF_FFFE, then 3 valid captures -> 0xFFFF_FFFF and stays there.
